// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm_if
// Description : Miss/memory/cache-write bundle between the fill FSM (master)
//               and the cache + memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic [DATA_W-1:0] memory_data;
   logic              memory_data_valid;
   logic              fsm_busy;
   logic              memory_read_en;
   logic [ADDR_W-1:0] memory_address;
   logic              write_data_array;
   logic              write_tag_array;
   logic [ADDR_W-1:0] cache_word_address;
   logic [DATA_W-1:0] cache_data;

   modport master (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, memory_read_en, memory_address, write_data_array,
             write_tag_array, cache_word_address, cache_data
   );

   modport slave (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, memory_read_en, memory_address, write_data_array,
             write_tag_array, cache_word_address, cache_data
   );
endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss-service controller: fetches one block word by word
//               from pipelined memory, writes it to the data array, then tags it.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int ADDR_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   cache_fill_fsm_if.master bus
);
   localparam int c_IDX_W = $clog2(WORDS_PER_BLOCK);
   localparam int c_CNT_W = c_IDX_W + 1;
   localparam int c_OFF_W = c_IDX_W + 1;
   localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(WORDS_PER_BLOCK);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [ADDR_W-1:0]  c_OFF_MASK = ADDR_W'((1 << c_OFF_W) - 1);
   localparam logic [ADDR_W-1:0]  c_WORD_INC = ADDR_W'(2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_TAG  = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [c_CNT_W-1:0]  r_req_cnt;
   logic [c_CNT_W-1:0]  r_rcv_cnt;
   logic                r_busy;
   logic                r_read_en;
   logic                r_tag_we;

   logic [ADDR_W-1:0]   w_aligned;
   logic [ADDR_W-1:0]   w_rcv_offset;
   logic                w_accept_word;

   assign w_aligned     = bus.miss_address & ~c_OFF_MASK;
   assign w_rcv_offset  = {{(ADDR_W-c_CNT_W-1){1'b0}}, r_rcv_cnt, 1'b0};
   // A valid beyond the last word of the block cannot be a real return; drop it.
   assign w_accept_word = (r_state == S_FILL) && bus.memory_data_valid && (r_rcv_cnt != c_FULL);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_mem_addr <= '0;
         r_req_cnt  <= '0;
         r_rcv_cnt  <= '0;
         r_busy     <= 1'b0;
         r_read_en  <= 1'b0;
         r_tag_we   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.miss_detected) begin
                  r_state    <= S_FILL;
                  r_base     <= w_aligned;
                  r_mem_addr <= w_aligned;
                  r_req_cnt  <= '0;
                  r_rcv_cnt  <= '0;
                  r_busy     <= 1'b1;
                  r_read_en  <= 1'b1;
               end
            end
            S_FILL: begin
               // Outputs are registered, so the request for the next cycle is prepared here.
               if (r_req_cnt != c_FULL) begin
                  r_req_cnt <= r_req_cnt + c_CNT_ONE;
                  if (r_req_cnt != c_LAST) begin
                     r_mem_addr <= r_mem_addr + c_WORD_INC;
                  end else begin
                     r_read_en <= 1'b0;
                  end
               end
               if (w_accept_word) begin
                  r_rcv_cnt <= r_rcv_cnt + c_CNT_ONE;
                  if (r_rcv_cnt == c_LAST) begin
                     r_state   <= S_TAG;
                     r_read_en <= 1'b0;
                     r_tag_we  <= 1'b1;
                  end
               end
            end
            S_TAG: begin
               r_state    <= S_IDLE;
               r_busy     <= 1'b0;
               r_tag_we   <= 1'b0;
               r_mem_addr <= r_base;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.fsm_busy           = r_busy;
   assign bus.memory_read_en     = r_read_en;
   assign bus.memory_address     = r_mem_addr;
   assign bus.write_tag_array    = r_tag_we;
   assign bus.write_data_array   = w_accept_word;
   assign bus.cache_word_address = w_accept_word ? (r_base + w_rcv_offset) : r_base;
   assign bus.cache_data         = bus.memory_data;
endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Scoreboard bench for cache_fill_fsm with a 4-cycle memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {logic [15:0] addr; int cyc;}   req_t;
   typedef struct {logic [15:0] addr; int ready;} pend_t;

   req_t        exp_req[$];
   logic [15:0] exp_wr[$];
   logic [15:0] exp_tag[$];
   pend_t       mem_q[$];

   int cyc         = 0;
   int n_tests     = 0;
   int n_fail      = 0;
   int tag_seen    = 0;
   int tag_cyc     = -1;
   int last_wr_cyc = -100;
   int wr_total    = 0;
   int delivered   = 0;
   int gap_at      = -1;
   int gap_left    = 0;
   bit rand_stall  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory: in-order, returns addr ^ 0xBEEF four cycles after each request.
   initial begin : memory_model
      pend_t p;
      bit    skip;
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.memory_data_valid = 1'b0;
         bus.memory_data       = 16'h0;
         if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
            skip = 1'b0;
            if (gap_left > 0 && delivered == gap_at) begin
               gap_left--;
               skip = 1'b1;
            end else if (rand_stall && $urandom_range(0, 2) == 0) begin
               skip = 1'b1;
            end
            if (!skip) begin
               p = mem_q.pop_front();
               bus.memory_data_valid = 1'b1;
               bus.memory_data       = p.addr ^ 16'hBEEF;
               delivered++;
            end
         end
         if (bus.memory_read_en) mem_q.push_back('{bus.memory_address, cyc + 4});
      end
   end

   initial begin : monitor
      req_t        r;
      logic [15:0] a;
      forever begin
         @(negedge clk);
         if (bus.memory_read_en) begin
            if (exp_req.size() == 0) chk("unexpected_req", 1, 0);
            else begin
               r = exp_req.pop_front();
               chk("req_addr", bus.memory_address, r.addr);
               chk("req_cycle", cyc, r.cyc);
            end
         end
         if (bus.write_data_array) begin
            if (exp_wr.size() == 0) chk("unexpected_data_wr", 1, 0);
            else begin
               a = exp_wr.pop_front();
               chk("wr_addr", bus.cache_word_address, a);
               chk("wr_data", bus.cache_data, a ^ 16'hBEEF);
            end
            last_wr_cyc = cyc;
            wr_total++;
         end
         if (bus.write_tag_array) begin
            if (exp_tag.size() == 0) chk("unexpected_tag_wr", 1, 0);
            else begin
               a = exp_tag.pop_front();
               chk("tag_addr", bus.cache_word_address, a);
               chk("tag_after_last_wr", cyc, last_wr_cyc + 1);
               chk("tag_no_data_wr", bus.write_data_array, 0);
            end
            tag_cyc = cyc;
            tag_seen++;
         end
      end
   end

   task automatic sync();
      @(negedge clk);
      #1;
   endtask

   task automatic push_fill(input logic [15:0] a, input int e);
      logic [15:0] base;
      base = a & 16'hFFF0;
      for (int i = 0; i < 8; i++) begin
         exp_req.push_back('{base + 16'(2 * i), e + i});
         exp_wr.push_back(base + 16'(2 * i));
      end
      exp_tag.push_back(base);
   endtask

   task automatic start_fill(input logic [15:0] a, input bit hold, output int e);
      chk("busy_before_miss", bus.fsm_busy, 0);
      bus.miss_detected = 1'b1;
      bus.miss_address  = a;
      e = cyc + 1;
      push_fill(a, e);
      sync();
      chk("busy_on_accept", bus.fsm_busy, 1);
      if (!hold) begin
         bus.miss_detected = 1'b0;
         bus.miss_address  = 16'($urandom);
      end
   endtask

   task automatic wait_tag(input int n0);
      for (int k = 0; k < 200 && tag_seen == n0; k++) sync();
      if (tag_seen == n0) chk("tag_timeout", 0, 1);
   endtask

   task automatic check_idle_after(input logic [15:0] a);
      sync();
      chk("busy_after_tag", bus.fsm_busy, 0);
      chk("idle_mem_addr", bus.memory_address, a & 16'hFFF0);
      chk("idle_cache_addr", bus.cache_word_address, a & 16'hFFF0);
      chk("req_left", exp_req.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
   endtask

   // tag_off < 0 means the tag cycle is not predictable (random stalls).
   task automatic run_fill(input logic [15:0] a, input int tag_off);
      int e, n0;
      n0 = tag_seen;
      start_fill(a, 1'b0, e);
      wait_tag(n0);
      if (tag_off >= 0) chk("tag_cycle", tag_cyc, e + tag_off);
      check_idle_after(a);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin : stimulus
      int e, n0, w0;
      rst                   = 1'b0;
      bus.miss_detected     = 1'b1;
      bus.miss_address      = 16'h1234;
      repeat (2) @(posedge clk);
      sync();
      chk("rst_busy", bus.fsm_busy, 0);
      chk("rst_read_en", bus.memory_read_en, 0);
      chk("rst_data_wr", bus.write_data_array, 0);
      chk("rst_tag_wr", bus.write_tag_array, 0);
      chk("rst_mem_addr", bus.memory_address, 0);
      chk("rst_cache_addr", bus.cache_word_address, 0);
      chk("rst_cache_data", bus.cache_data, 0);
      rst = 1'b1;
      run_fill(16'h1234, 12);

      // nominal fill
      repeat (2) sync();
      run_fill(16'h1A36, 12);

      // three-cycle hole in returns after the fourth word
      repeat (2) sync();
      gap_at   = delivered + 4;
      gap_left = 3;
      run_fill(16'h2468, 15);
      chk("gap_consumed", gap_left, 0);

      // miss held and address changed during fill
      repeat (2) sync();
      n0 = tag_seen;
      start_fill(16'h1A36, 1'b1, e);
      bus.miss_address = 16'h4400;
      push_fill(16'h4400, e + 14);
      wait_tag(n0);
      chk("tag_cycle_first", tag_cyc, e + 12);
      sync();
      chk("busy_gap_idle", bus.fsm_busy, 0);
      sync();
      chk("busy_second_fill", bus.fsm_busy, 1);
      bus.miss_detected = 1'b0;
      wait_tag(n0 + 1);
      chk("tag_cycle_second", tag_cyc, e + 26);
      check_idle_after(16'h4400);

      // top of address space
      repeat (2) sync();
      run_fill(16'hFFFF, 12);

      // reset after the third data write
      repeat (2) sync();
      w0 = wr_total;
      start_fill(16'h5A5A, 1'b0, e);
      for (int k = 0; k < 50 && wr_total < w0 + 3; k++) sync();
      chk("wr_count_before_reset", wr_total - w0, 3);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_req.delete();
      exp_wr.delete();
      exp_tag.delete();
      sync();
      rst = 1'b1;
      n0  = tag_seen;
      for (int k = 0; k < 12; k++) begin
         sync();
         chk("busy_after_reset", bus.fsm_busy, 0);
      end
      chk("no_tag_after_reset", tag_seen - n0, 0);
      run_fill(16'h0100, 12);

      // randomized misses, optionally with random return stalls
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(1, 3)) sync();
         rand_stall = 1'($urandom_range(0, 1));
         run_fill(16'($urandom), rand_stall ? -1 : 12);
         rand_stall = 1'b0;
      end

      repeat (4) sync();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
